// File: rtl/stack_sequencer.sv
// stack_sequencer: buffers a nibble program and replays it into stack_cpu with per-opcode cycle timing
module stack_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [3:0]    wr_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   prog_len,
   output logic [AW-1:0] pc,
   output logic          cpu_rst,
   output logic [3:0]    cpu_inbits
);
   typedef enum logic [2:0] {IDLE, RST, OP, EXEC, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] buf_q [DEPTH];
   logic [AW:0] prog_len_q, prog_len_d, npc, opnd_idx;
   logic [AW-1:0] pc_q, pc_d;
   logic [1:0] cnt_q, cnt_d, e_len;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_rst_q, cpu_rst_d;
   logic [3:0] bits_q, bits_d, op, opnd;
   logic has_opnd, opnd_ok, accept, wr_ok;
   // decode the opcode at pc: operand presence, execute length, next pc
   always_comb begin
      op       = buf_q[pc_q];
      has_opnd = op inside {4'h1, 4'h6, 4'h7, 4'h8};
      e_len    = (op == 4'h9 || op == 4'hA) ? 2'd3 :
                 (has_opnd || op == 4'h2 || op == 4'h5) ? 2'd2 : 2'd1;
      opnd_idx = {1'b0, pc_q} + 1'b1;
      opnd_ok  = opnd_idx < prog_len_q;
      opnd     = opnd_ok ? buf_q[opnd_idx[AW-1:0]] : 4'h0;
      npc      = {1'b0, pc_q} + (has_opnd ? (AW+1)'(2) : (AW+1)'(1));
      accept   = state_q == IDLE || state_q == DONE;
      wr_ok    = accept && wr_en && !clear;
   end
   // loading, run FSM and registered output values for the next cycle
   always_comb begin
      state_d    = state_q;
      prog_len_d = prog_len_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      cpu_rst_d  = 1'b0;
      bits_d     = 4'h0;
      if (accept && clear) begin
         prog_len_d = '0;
         err_d      = 1'b0;
      end else if (wr_ok) begin
         if (prog_len_q[AW]) err_d = 1'b1;
         else prog_len_d = prog_len_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            cpu_rst_d = cpu_rst_q && !start && !wr_en;
            if (start && prog_len_q == '0) state_d = DONE;
            else if (start) begin
               state_d   = RST;
               pc_d      = '0;
               cpu_rst_d = 1'b1;
            end
         end
         RST: begin
            state_d = OP;
            bits_d  = op;
         end
         OP: begin
            state_d = EXEC;
            cnt_d   = e_len;
            bits_d  = has_opnd ? opnd : 4'h0;
            if (has_opnd && !opnd_ok) err_d = 1'b1;
         end
         EXEC: begin
            bits_d = bits_q;
            if (cnt_q == 2'd1) begin
               pc_d    = npc[AW-1:0];
               state_d = npc >= prog_len_q ? DONE : OP;
               bits_d  = npc >= prog_len_q ? 4'h0 : buf_q[npc[AW-1:0]];
            end else cnt_d = cnt_q - 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = state_d inside {RST, OP, EXEC};
      done_d = state_d == DONE;
   end
   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prog_len_q <= '0;
         pc_q       <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cpu_rst_q  <= 1'b1;
         bits_q     <= 4'h0;
      end else begin
         state_q    <= state_d;
         prog_len_q <= prog_len_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cpu_rst_q  <= cpu_rst_d;
         bits_q     <= bits_d;
      end
   end
   // program buffer; contents need no reset since prog_len hides them
   always_ff @(posedge clk) begin
      if (wr_ok && !prog_len_q[AW]) buf_q[prog_len_q[AW-1:0]] <= wr_data;
   end
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign prog_len   = prog_len_q;
   assign pc         = pc_q;
   assign cpu_rst    = cpu_rst_q;
   assign cpu_inbits = bits_q;
endmodule
